// File: rtl/if_stage_if.sv
// Bus bundle between the instruction-fetch stage and its surroundings (IMEM, hazard unit, EX, decode).
// IF_STAGE_PERF_EN adds the two performance-counter outputs.
interface if_stage_if;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        fetch_fault;
`ifdef IF_STAGE_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_redirect_cnt;
`endif

    // master is the fetch stage itself; slave is the surrounding pipeline/memory.
    modport master (
        input  stall, redirect_valid, redirect_pc, imem_instr,
`ifdef IF_STAGE_PERF_EN
        output perf_fetch_cnt, perf_redirect_cnt,
`endif
        output imem_pc, if_id_pc, if_id_instr, if_id_valid, fetch_fault
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_instr,
`ifdef IF_STAGE_PERF_EN
        input  perf_fetch_cnt, perf_redirect_cnt,
`endif
        input  imem_pc, if_id_pc, if_id_instr, if_id_valid, fetch_fault
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses IMEM and fills the IF/ID register.
// Optional IF_STAGE_PERF_EN adds fetch and redirect counters.
module if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned IMEM_SIZE = 1024,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic        clk,
    input logic        rst_n,
    if_stage_if.master bus
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    localparam logic [31:0] LAST_PC = 32'(IMEM_SIZE - 4);

    state_t      r_state, w_state_n;
    logic [31:0] r_pc, w_pc_n;
    logic [31:0] r_if_pc, w_if_pc_n;
    logic [31:0] r_if_instr, w_if_instr_n;
    logic        r_if_valid, w_if_valid_n;
    logic        r_fault, w_fault_n;
    logic        w_fetch, w_redirect;
    logic        w_bad_target;

    assign w_bad_target = (bus.redirect_pc[1:0] != 2'b00) || (bus.redirect_pc > LAST_PC);

    // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_if_pc_n    = r_if_pc;
        w_if_instr_n = r_if_instr;
        w_if_valid_n = r_if_valid;
        w_fault_n    = r_fault;
        w_fetch      = 1'b0;
        w_redirect   = 1'b0;
        unique case (r_state)
            BOOT: w_state_n = RUN;
            RUN: begin
                if (bus.redirect_valid && w_bad_target) begin
                    w_state_n    = HALT;
                    w_fault_n    = 1'b1;
                    w_if_instr_n = NOP_INSTR;
                    w_if_valid_n = 1'b0;
                end else if (bus.redirect_valid) begin
                    // Redirect wins over stall; the wrong-path word becomes a bubble.
                    w_redirect   = 1'b1;
                    w_pc_n       = bus.redirect_pc;
                    w_if_instr_n = NOP_INSTR;
                    w_if_valid_n = 1'b0;
                end else if (bus.stall) begin
                    w_state_n = RUN;
                end else if (r_pc > LAST_PC) begin
                    w_state_n    = HALT;
                    w_fault_n    = 1'b1;
                    w_if_valid_n = 1'b0;
                end else begin
                    w_fetch      = 1'b1;
                    w_if_pc_n    = r_pc;
                    w_if_instr_n = bus.imem_instr;
                    w_if_valid_n = 1'b1;
                    w_pc_n       = r_pc + 32'd4;
                end
            end
            HALT: w_state_n = HALT;
            default: w_state_n = BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= BOOT;
            r_pc       <= RESET_PC;
            r_if_pc    <= '0;
            r_if_instr <= NOP_INSTR;
            r_if_valid <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_pc       <= w_pc_n;
            r_if_pc    <= w_if_pc_n;
            r_if_instr <= w_if_instr_n;
            r_if_valid <= w_if_valid_n;
            r_fault    <= w_fault_n;
        end
    end

    assign bus.imem_pc     = r_pc;
    assign bus.if_id_pc    = r_if_pc;
    assign bus.if_id_instr = r_if_instr;
    assign bus.if_id_valid = r_if_valid;
    assign bus.fetch_fault = r_fault;

`ifdef IF_STAGE_PERF_EN
    logic [31:0] r_perf_fetch, r_perf_redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch    <= '0;
            r_perf_redirect <= '0;
        end else begin
            if (w_fetch)    r_perf_fetch    <= r_perf_fetch + 32'd1;
            if (w_redirect) r_perf_redirect <= r_perf_redirect + 32'd1;
        end
    end

    assign bus.perf_fetch_cnt    = r_perf_fetch;
    assign bus.perf_redirect_cnt = r_perf_redirect;
`else
    logic w_unused;
    assign w_unused = w_fetch ^ w_redirect;
`endif
endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed boot/stall/redirect/fault steps plus randomized traffic
// compared against a behavioural model of the fetch rules.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int checks = 0;
    int failures = 0;

    if_stage_if bus_main();
    if_stage_if bus_boot();
    if_stage_if bus_small();

    if_stage #(.RESET_PC(32'd0), .IMEM_SIZE(1024), .NOP_INSTR(NOP))
        u_main (.clk(clk), .rst_n(rst_n), .bus(bus_main.master));
    if_stage #(.RESET_PC(32'd4), .IMEM_SIZE(1024), .NOP_INSTR(NOP))
        u_boot (.clk(clk), .rst_n(rst_n), .bus(bus_boot.master));
    if_stage #(.RESET_PC(32'd0), .IMEM_SIZE(16), .NOP_INSTR(NOP))
        u_small (.clk(clk), .rst_n(rst_n), .bus(bus_small.master));

    assign bus_main.imem_instr  = mem[bus_main.imem_pc[9:2]];
    assign bus_boot.imem_instr  = mem[bus_boot.imem_pc[9:2]];
    assign bus_small.imem_instr = mem[bus_small.imem_pc[9:2]];
    assign bus_boot.stall           = 1'b0;
    assign bus_boot.redirect_valid  = 1'b0;
    assign bus_boot.redirect_pc     = 32'd0;
    assign bus_small.stall          = 1'b0;
    assign bus_small.redirect_valid = 1'b0;
    assign bus_small.redirect_pc    = 32'd0;

    // Behavioural model of the main instance (RESET_PC=0, IMEM_SIZE=1024).
    logic [31:0] m_pc, m_if_pc, m_if_instr;
    logic        m_if_valid, m_fault, m_halted;
    int          m_edges;
    logic [31:0] m_fetch_cnt, m_redirect_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pc = 32'd0; m_if_pc = 32'd0; m_if_instr = NOP;
        m_if_valid = 1'b0; m_fault = 1'b0; m_halted = 1'b0; m_edges = 0;
        m_fetch_cnt = 32'd0; m_redirect_cnt = 32'd0;
    endtask

    // One rising edge worth of fetch rules, using the inputs presented before the edge.
    task automatic m_edge();
        longint unsigned tgt;
        tgt = {32'd0, bus_main.redirect_pc};
        if (m_edges > 0 && !m_halted) begin
            if (bus_main.redirect_valid && (tgt % 4 != 0 || tgt + 4 > 1024)) begin
                m_halted = 1'b1; m_fault = 1'b1; m_if_instr = NOP; m_if_valid = 1'b0;
            end else if (bus_main.redirect_valid) begin
                m_pc = bus_main.redirect_pc; m_if_instr = NOP; m_if_valid = 1'b0;
                m_redirect_cnt++;
            end else if (bus_main.stall) begin
                m_pc = m_pc;
            end else if ({32'd0, m_pc} + 4 > 1024) begin
                m_halted = 1'b1; m_fault = 1'b1; m_if_valid = 1'b0;
            end else begin
                m_if_pc = m_pc; m_if_instr = mem[m_pc / 4]; m_if_valid = 1'b1;
                m_pc = m_pc + 4;
                m_fetch_cnt++;
            end
        end
        m_edges++;
    endtask

    task automatic check_main();
        check("main.imem_pc", bus_main.imem_pc, m_pc);
        check("main.if_id_pc", bus_main.if_id_pc, m_if_pc);
        check("main.if_id_instr", bus_main.if_id_instr, m_if_instr);
        check("main.if_id_valid", 32'(bus_main.if_id_valid), 32'(m_if_valid));
        check("main.fetch_fault", 32'(bus_main.fetch_fault), 32'(m_fault));
`ifdef IF_STAGE_PERF_EN
        check("main.perf_fetch", bus_main.perf_fetch_cnt, m_fetch_cnt);
        check("main.perf_redirect", bus_main.perf_redirect_cnt, m_redirect_cnt);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        #1;
        check_main();
    endtask

    // Called one time unit after an edge; asserts reset asynchronously and releases it mid-cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_reset();
        check_main();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] pc_before;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[1]  = 32'h0040_0093;
        mem[2]  = 32'h0010_0113;
        mem[3]  = 32'h0020_81b3;
        mem[10] = 32'h0020_e4b3;
        bus_main.stall = 1'b0;
        bus_main.redirect_valid = 1'b0;
        bus_main.redirect_pc = 32'd0;
        m_reset();

        // Reset state.
        #12;
        check_main();
        check("boot.imem_pc@reset", bus_boot.imem_pc, 32'd4);
        check("boot.valid@reset", 32'(bus_boot.if_id_valid), 32'd0);
        rst_n = 1'b1;

        // Boot: edge 1 still a bubble, edge 2 presents the word at RESET_PC.
        step();
        check("boot.valid@e1", 32'(bus_boot.if_id_valid), 32'd0);
        check("boot.instr@e1", bus_boot.if_id_instr, NOP);
        step();
        check("boot.instr@e2", bus_boot.if_id_instr, 32'h0040_0093);
        check("boot.pc@e2", bus_boot.if_id_pc, 32'd4);
        check("boot.imem_pc@e2", bus_boot.imem_pc, 32'd8);
        check("small.pc@e2", bus_small.if_id_pc, 32'd0);
        step();
        check("small.pc@e3", bus_small.if_id_pc, 32'd4);
        step();
        check("main.seq_pc8", bus_main.if_id_pc, 32'd8);
        check("main.seq_instr8", bus_main.if_id_instr, 32'h0010_0113);

        // Stall while IF/ID holds PC 8; the small instance keeps running into its range fault.
        bus_main.stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            check("stall.pc_hold", bus_main.if_id_pc, 32'd8);
            check("stall.instr_hold", bus_main.if_id_instr, 32'h0010_0113);
            check("stall.imem_pc_hold", bus_main.imem_pc, 32'd12);
            if (s == 0) begin
                check("small.pc@e5", bus_small.if_id_pc, 32'd12);
                check("small.instr@e5", bus_small.if_id_instr, 32'h0020_81b3);
            end else if (s == 1) begin
                check("small.fault@e6", 32'(bus_small.fetch_fault), 32'd1);
                check("small.valid@e6", 32'(bus_small.if_id_valid), 32'd0);
            end
        end
        bus_main.stall = 1'b0;
        step();
        check("stall.release_pc", bus_main.if_id_pc, 32'd12);
        check("stall.release_instr", bus_main.if_id_instr, 32'h0020_81b3);

        // Redirect to 40 together with stall: bubble, then the target word.
        bus_main.stall = 1'b1;
        bus_main.redirect_valid = 1'b1;
        bus_main.redirect_pc = 32'd40;
        step();
        check("redir.bubble", 32'(bus_main.if_id_valid), 32'd0);
        check("redir.imem_pc", bus_main.imem_pc, 32'd40);
        bus_main.stall = 1'b0;
        bus_main.redirect_valid = 1'b0;
        step();
        check("redir.target_pc", bus_main.if_id_pc, 32'd40);
        check("redir.target_instr", bus_main.if_id_instr, 32'h0020_e4b3);

        // Randomized traffic against the model, with occasional illegal targets and resets.
        for (int n = 0; n < 400; n++) begin
            if ((m_halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) do_reset();
            bus_main.stall = ($urandom_range(0, 3) == 0);
            bus_main.redirect_valid = ($urandom_range(0, 6) == 0);
            bus_main.redirect_pc = ($urandom_range(0, 9) == 0) ? $urandom
                                                               : (32'($urandom_range(0, 255)) << 2);
            step();
        end

        // Misaligned redirect: fault, freeze for 10 cycles, then asynchronous clear.
        bus_main.stall = 1'b0;
        bus_main.redirect_valid = 1'b0;
        do_reset();
        step();
        step();
        step();
        pc_before = m_pc;
        bus_main.redirect_valid = 1'b1;
        bus_main.redirect_pc = 32'h22;
        step();
        check("misalign.fault", 32'(bus_main.fetch_fault), 32'd1);
        check("misalign.valid", 32'(bus_main.if_id_valid), 32'd0);
        check("misalign.pc_kept", bus_main.imem_pc, pc_before);
        for (int k = 0; k < 10; k++) begin
            bus_main.redirect_valid = 1'b1;
            bus_main.redirect_pc = 32'($urandom_range(0, 255)) << 2;
            bus_main.stall = $urandom_range(0, 1) == 1;
            step();
        end
        check("halt.pc_frozen", bus_main.imem_pc, pc_before);
        bus_main.redirect_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("halt.reset_fault", 32'(bus_main.fetch_fault), 32'd0);
        check("halt.reset_pc", bus_main.imem_pc, 32'd0);
        check("halt.reset_instr", bus_main.if_id_instr, NOP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage that owns the program counter, drives the address input of the combinational byte-addressed `IMEM`, and registers the returned word into the IF/ID pipeline register. It sits directly upstream of `IMEM` and directly upstream of decode. It accepts stall requests from the hazard logic and branch/jump redirects from EX.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value after reset; must be word-aligned.
- `IMEM_SIZE`, 1024: IMEM size in bytes; used for the out-of-range fault check.
- `NOP_INSTR`, 32'h0000_0013: instruction word inserted into IF/ID on flush and reset.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `stall`, input, 1: hold the PC and IF/ID contents.
- `redirect_valid`, input, 1: EX-resolved taken branch or jump.
- `redirect_pc`, input, 32: target address for the redirect.
- `imem_pc`, output, 32: address to `IMEM.PC`; equals the current PC register.
- `imem_instr`, input, 32: word returned combinationally by `IMEM.instruction`.
- `if_id_pc`, output, 32: PC of the instruction held in IF/ID.
- `if_id_instr`, output, 32: instruction held in IF/ID.
- `if_id_valid`, output, 1: IF/ID holds a real instruction.
- `fetch_fault`, output, 1: sticky fault flag (misaligned or out-of-range PC).

## Operation
- FSM states are BOOT, RUN and HALT. Reset forces BOOT.
- **BOOT**
  - Lasts exactly one cycle.
  - PC holds `RESET_PC` and IF/ID stays invalid.
  - `stall` and `redirect_valid` are ignored.
  - Next state is RUN.
- **RUN**, evaluated each edge in this priority order:
  1. `redirect_valid` with `redirect_pc[1:0]!=0`, or `redirect_pc > IMEM_SIZE-4`: go to HALT, set `fetch_fault`, load `NOP_INSTR` into IF/ID with valid=0, and leave the PC unchanged.
  2. `redirect_valid` (legal target): PC <= `redirect_pc`; IF/ID <= {`NOP_INSTR`, valid=0}, which flushes the wrong-path word. A redirect overrides `stall`.
  3. `stall`: the PC and all IF/ID outputs hold their values.
  4. Current PC > `IMEM_SIZE-4`: go to HALT, set `fetch_fault`, IF/ID valid=0.
  5. Otherwise: `if_id_pc` <= PC, `if_id_instr` <= `imem_instr`, `if_id_valid` <= 1, and PC <= PC+4.
- **HALT**
  - PC, IF/ID and `fetch_fault=1` are frozen.
  - `if_id_valid=0`.
  - All inputs are ignored.
  - The only exit is `rst_n` low.
- PC arithmetic is 32-bit modulo 2^32. Wrap-around is unreachable because of the range check.
- `imem_pc` is the PC register itself, with no combinational path from any input. There is therefore no loop through `IMEM`.

## Timing
- Reset values:
  - PC = `RESET_PC`
  - `if_id_pc` = 0
  - `if_id_instr` = `NOP_INSTR`
  - `if_id_valid` = 0
  - `fetch_fault` = 0
  - state = BOOT
- Asserting `rst_n` mid-operation returns the block to these values immediately (asynchronously), including from HALT.
- After `rst_n` rises:
  - Edge 1: BOOT -> RUN.
  - Edge 2: IF/ID holds the word at `RESET_PC`, valid=1.
- Fetch latency is one cycle: the word at address A appears on `if_id_*` one edge after `imem_pc`=A.
- Throughput is one instruction per cycle when not stalled.
- Redirect penalty:
  - On the edge that samples `redirect_valid`, IF/ID becomes a bubble.
  - On the next edge, IF/ID holds the target instruction.
  - Flushing ID/EX is the responsibility of the pipeline-control block, not this one.
- A stall that persists across cycles holds the block indefinitely, with no timeout.

## Configuration
- `IF_STAGE_PERF_EN`: when defined, the block adds two 32-bit outputs, `perf_fetch_cnt` and `perf_redirect_cnt`, both reset to 0.
  - `perf_fetch_cnt` increments on every edge that loads a valid word into IF/ID.
  - `perf_redirect_cnt` increments on every accepted legal redirect.
  - Both counters wrap modulo 2^32 and freeze in HALT.
- When the macro is undefined, the ports and counters are absent and the rest of the behaviour is identical.

## Test plan
- **Reset/boot:** hold `rst_n`=0, then release it with IMEM loaded with `0x00400093` at address 4 and `RESET_PC`=4.
  - Before edge 2: `if_id_valid`=0 and `if_id_instr`=0x00000013.
  - After edge 2: `if_id_instr`=0x00400093, `if_id_pc`=4, `imem_pc`=8.
- **Sequential fetch:** from `RESET_PC`=0, run 6 cycles. IF/ID shows PCs 0,4,8,12,16 in consecutive cycles with matching IMEM words, e.g. PC 12 -> 0x002081b3.
- **Stall:** assert `stall` for 3 cycles while `if_id_pc`=8. `if_id_pc`/`if_id_instr` hold 8/0x00100113 and `imem_pc` holds 12; on release, the next edge shows PC 12.
- **Redirect:**
  - Pulse `redirect_valid` with `redirect_pc`=40 together with `stall`=1. The next edge gives `if_id_valid`=0 and `imem_pc`=40; the following edge gives `if_id_pc`=40, `if_id_instr`=0x0020e4b3.
  - With `IF_STAGE_PERF_EN`, `perf_redirect_cnt`=1.
- **Misaligned fault:**
  - A redirect to 0x22 sets `fetch_fault`=1, `if_id_valid`=0 and leaves the PC unchanged. The block then stays frozen for 10 cycles despite further redirects.
  - Asserting `rst_n`=0 clears the fault immediately.
- **Range fault:** with `IMEM_SIZE`=16, run from 0. PCs 0–12 are fetched; with PC=16 the next edge sets `fetch_fault`=1 and IF/ID goes invalid.
